// File: rtl/led_mode_ctrl.sv
// Step sequencer for the active-low 4-LED bank: clock divider plus four display modes.
// A mode key picks the mode and a pause key freezes the display.
module led_mode_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic       tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [3:0] PAT_R   = 4'b0111;
    localparam logic [3:0] PAT_L   = 4'b1110;
    localparam logic [3:0] PAT_ALL = 4'b0000;

    typedef enum logic [1:0] {
        RUN_R  = 2'd0,
        RUN_L  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_left_q, dir_left_d;
    logic [3:0]       led_d;
    logic             paused_d;
    logic             tick_d;
    logic             step;
    logic [3:0]       rot_r, rot_l;
    logic             walk_ok;

    function automatic logic [3:0] init_pat(input mode_e m);
        case (m)
            RUN_L:   init_pat = PAT_L;
            BLINK:   init_pat = PAT_ALL;
            default: init_pat = PAT_R;
        endcase
    endfunction

    assign rot_r   = {led[0], led[3:1]};
    assign rot_l   = {led[2:0], led[3]};
    assign walk_ok = (led == 4'b0111) || (led == 4'b1011) ||
                     (led == 4'b1101) || (led == 4'b1110);
    assign step    = (cnt_q == CNT_LAST) && !paused;
    assign mode    = mode_q;

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= RUN_R;
        else     mode_q <= mode_d;
    end

    // Mode next-state: each key_mode pulse advances one mode, wrapping
    always_comb begin
        mode_d = mode_q;
        if (key_mode) mode_d = mode_e'(2'(mode_q + 2'd1));
    end

    // Datapath next values; a mode change overrides any coincident step
    always_comb begin
        led_d      = led;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        tick_d     = 1'b0;
        paused_d   = paused ^ key_pause;
        if (key_mode) begin
            led_d      = init_pat(mode_d);
            cnt_d      = '0;
            dir_left_d = 1'b0;
        end else begin
            if (!paused) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (step) begin
                tick_d = 1'b1;
                case (mode_q)
                    RUN_R:  led_d = walk_ok ? rot_r : PAT_R;
                    RUN_L:  led_d = walk_ok ? rot_l : PAT_L;
                    BOUNCE: begin
                        if (!walk_ok) begin
                            led_d      = PAT_R;
                            dir_left_d = 1'b0;
                        end else begin
                            led_d = dir_left_q ? rot_l : rot_r;
                            if (led_d == PAT_L)      dir_left_d = 1'b1;
                            else if (led_d == PAT_R) dir_left_d = 1'b0;
                        end
                    end
                    default: led_d = (led == 4'b0000 || led == 4'b1111) ? ~led : PAT_ALL;
                endcase
            end
        end
    end

    // Registered outputs and divider state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led        <= PAT_R;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            paused     <= 1'b0;
            tick       <= 1'b0;
        end else begin
            led        <= led_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
            paused     <= paused_d;
            tick       <= tick_d;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl at TICK_DIV=4 with hand-computed LED sequences.
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode;
    logic       key_pause;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;

    led_mode_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_pause (key_pause),
        .led       (led),
        .mode      (mode),
        .paused    (paused),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Three quiet edges then the step edge, which must show tick and the new pattern
    task automatic run_step(input string tag, input logic [3:0] exp_led);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check({tag, "_notick"}, 8'(tick), 8'd0);
        end
        cyc();
        check({tag, "_tick"}, 8'(tick), 8'd1);
        check({tag, "_led"}, 8'(led), 8'(exp_led));
    endtask

    initial begin
        rst       = 1'b1;
        key_mode  = 1'b0;
        key_pause = 1'b0;
        repeat (2) cyc();
        check("rst_led", 8'(led), 8'b0111);
        check("rst_mode", 8'(mode), 8'd0);
        check("rst_paused", 8'(paused), 8'd0);
        check("rst_tick", 8'(tick), 8'd0);
        rst = 1'b0;

        // RUN_R idle
        run_step("runr1", 4'b1011);
        run_step("runr2", 4'b1101);
        run_step("runr3", 4'b1110);
        run_step("runr4", 4'b0111);
        check("runr_mode", 8'(mode), 8'd0);

        // RUN_L
        key_mode = 1'b1; cyc(); key_mode = 1'b0;
        check("runl_mode", 8'(mode), 8'd1);
        check("runl_init", 8'(led), 8'b1110);
        check("runl_tick0", 8'(tick), 8'd0);
        run_step("runl1", 4'b1101);
        run_step("runl2", 4'b1011);
        run_step("runl3", 4'b0111);
        run_step("runl4", 4'b1110);

        // BOUNCE
        key_mode = 1'b1; cyc(); key_mode = 1'b0;
        check("bnc_mode", 8'(mode), 8'd2);
        check("bnc_init", 8'(led), 8'b0111);
        run_step("bnc1", 4'b1011);
        run_step("bnc2", 4'b1101);
        run_step("bnc3", 4'b1110);
        run_step("bnc4", 4'b1101);
        run_step("bnc5", 4'b1011);
        run_step("bnc6", 4'b0111);
        run_step("bnc7", 4'b1011);
        run_step("bnc8", 4'b1101);
        run_step("bnc9", 4'b1110);
        run_step("bnc10", 4'b1101);

        // Pause while moving left, then async reset
        key_pause = 1'b1; cyc(); key_pause = 1'b0;
        check("pre_rst_paused", 8'(paused), 8'd1);
        rst = 1'b1;
        #1;
        check("arst_led", 8'(led), 8'b0111);
        check("arst_mode", 8'(mode), 8'd0);
        check("arst_paused", 8'(paused), 8'd0);
        check("arst_tick", 8'(tick), 8'd0);
        cyc();
        rst = 1'b0;
        run_step("post_rst", 4'b1011);

        // BLINK via three back-to-back pulses
        key_mode = 1'b1; repeat (3) cyc(); key_mode = 1'b0;
        check("blk_mode", 8'(mode), 8'd3);
        check("blk_init", 8'(led), 8'b0000);
        check("blk_tick0", 8'(tick), 8'd0);
        run_step("blk1", 4'b1111);
        run_step("blk2", 4'b0000);
        key_mode = 1'b1; cyc(); key_mode = 1'b0;
        check("wrap_mode", 8'(mode), 8'd0);
        check("wrap_led", 8'(led), 8'b0111);

        // Pause at cnt=2, hold, resume
        repeat (2) cyc();
        key_pause = 1'b1; cyc(); key_pause = 1'b0;
        check("pause_on", 8'(paused), 8'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("pause_led", 8'(led), 8'b0111);
            check("pause_tick", 8'(tick), 8'd0);
        end
        key_pause = 1'b1; cyc(); key_pause = 1'b0;
        check("resume_off", 8'(paused), 8'd0);
        check("resume_tick0", 8'(tick), 8'd0);
        cyc();
        check("resume_tick", 8'(tick), 8'd1);
        check("resume_led", 8'(led), 8'b1011);

        // key_mode on the step edge
        repeat (3) cyc();
        key_mode = 1'b1; cyc(); key_mode = 1'b0;
        check("kstep_mode", 8'(mode), 8'd1);
        check("kstep_tick", 8'(tick), 8'd0);
        check("kstep_led", 8'(led), 8'b1110);
        run_step("kstep_next", 4'b1101);

        // key_mode and key_pause together
        key_mode = 1'b1; key_pause = 1'b1; cyc(); key_mode = 1'b0; key_pause = 1'b0;
        check("both_mode", 8'(mode), 8'd2);
        check("both_paused", 8'(paused), 8'd1);
        check("both_led", 8'(led), 8'b0111);
        repeat (6) cyc();
        check("both_hold", 8'(led), 8'b0111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Sequencer for the board's 4-LED bank. It divides the system clock into a step tick and runs one of four display modes: rotate right, rotate left, bounce, or blink. Modes are selected by a mode-key pulse, and a pause key freezes the display. It sits between the debounced key inputs and the active-low LED pins, and replaces the separate 1 Hz divider plus fixed rotate-right block.

## Interface
Parameters:
- TICK_DIV, 50_000_000: system clocks per display step. Legal range is TICK_DIV >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- key_mode  in  1  single-cycle pulse, synchronous to clk and already debounced; advances the mode.
- key_pause  in  1  single-cycle pulse, synchronous and debounced; toggles pause.
- led  out  4  LED drive, active-low (0 = lit), registered.
- mode  out  2  current mode: 0 RUN_R, 1 RUN_L, 2 BOUNCE, 3 BLINK.
- paused  out  1  1 while the display is frozen.
- tick  out  1  one-cycle pulse coincident with each new led value produced by a step.

## Operation
Reset state (while rst=1, and immediately on assertion):
- mode=0, led=4'b0111, paused=0, tick=0.
- Internal state: cnt=0, bounce direction = right.

Divider:
- cnt counts 0..TICK_DIV-1 and wraps to 0.
- cnt holds its value while paused=1.
- A "step" occurs on the edge where cnt==TICK_DIV-1 and paused=0.

Mode FSM:
- key_mode advances the mode in the order RUN_R -> RUN_L -> BOUNCE -> BLINK -> RUN_R.
- On a mode change, at the same edge: led loads the new mode's initial pattern, cnt clears to 0, and bounce direction resets to right.
- paused is unchanged by a mode change.

Step actions per mode (pattern values are active-low):
- RUN_R: initial 0111. Each step: led <= {led[0],led[3:1]}. Sequence is 0111, 1011, 1101, 1110, 0111.
- RUN_L: initial 1110. Each step: led <= {led[2:0],led[3]}. Sequence is 1110, 1101, 1011, 0111, 1110.
- BOUNCE: initial 0111, direction right. Each step shifts one position in the current direction.
  - When the new value is 1110, direction becomes left.
  - When the new value is 0111, direction becomes right.
  - Full sequence: 0111, 1011, 1101, 1110, 1101, 1011, 0111, 1011, …
- BLINK: initial 0000 (all lit). Each step: led <= ~led.

Pause:
- key_pause toggles paused.
- While paused, led, cnt and direction hold. Mode changes are still accepted.

Robustness:
- Any led value outside the legal patterns of the current mode (impossible in normal operation) loads that mode's initial pattern on the next step.

Simultaneous events:
- key_mode together with a step: the mode change wins. The step is discarded and tick stays 0.
- key_mode together with key_pause: both take effect in the same cycle.
- key_pause together with a step: the step completes first, then paused toggles at that same edge.

Reset mid-operation: all state returns to the reset values asynchronously, with no partial step.

## Timing
- First step after rst deasserts: the edge at which cnt reaches TICK_DIV-1, which is TICK_DIV rising edges after release.
- Step period: exactly TICK_DIV clocks when no keys are pressed.
- tick is a registered pulse. It is high for the one cycle following the step edge, i.e. the first cycle the new led value is visible.
- tick is never asserted on a mode change or on a reset.
- key_mode latency: one edge. mode and led show their new values in the following cycle.
- key_mode restarts the step period: the next step comes TICK_DIV edges after the mode-change edge.
- Resume after pause: the remaining count continues from the held cnt; the divider does not restart.
- All outputs are registered. There is no combinational path from the key inputs to the outputs.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then idle 17 clocks: led reads 0111, 1011, 1101, 1110, 0111 with steps at edges 4, 8, 12, 16. One tick per step; mode=0.
- One key_mode pulse: mode=1 and led=1110 the next cycle. After 4 edges led=1101, then 1011, then 0111, then 1110.
- Two key_mode pulses, then run 8 steps in BOUNCE: led sequence is 0111, 1011, 1101, 1110, 1101, 1011, 0111, 1011, 1101.
- BLINK (three key_mode pulses): led=0000, then toggles 1111, 0000 every 4 clocks. A fourth key_mode pulse returns mode=0 with led=0111.
- Pause mid-period: pulse key_pause when cnt=2 and hold 10 clocks. led is frozen and tick=0 throughout. A second key_pause pulse makes the next step occur 2 clocks later.
- Corner cases:
  - key_mode on the step edge: mode advances, tick=0, led=initial pattern.
  - Assert rst mid-BOUNCE while moving left: led=0111, mode=0 and paused=0 immediately; the first step after release gives 1011.
